counter_ctrl: RTL and testbench

Control sequencer for the 32-bit free-running counter datapath on the FPGA board. It debounces the two push keys and the 4-bit rotary switch, and runs a run/pause/clear state machine. It drives the counter's enable and clear inputs and the output tap-select (shift amount) used to pick the 16-bit window shown on the LEDs. This replaces raw key sampling in the counter with clean, single-event control.

---
 rtl/counter_pkg.sv | 13 +
 rtl/counter_ctrl_if.sv | 23 ++
 rtl/debounce_filter.sv | 54 +++++
 rtl/counter_ctrl.sv | 89 ++++++++
 tb/tb_counter_ctrl.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared state encoding and debounce defaults for counter_ctrl
package counter_pkg;

  localparam int unsigned P_DB_CNT_DEF = 500000;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_CLEAR = 2'b11
  } state_t;

endpackage

// File: rtl/counter_ctrl_if.sv
// rtl/counter_ctrl_if.sv - raw board inputs and counter control outputs of counter_ctrl
interface counter_ctrl_if;

  logic       i_key1_mode;
  logic       i_key2_clear;
  logic [3:0] i_rotary;
  logic       o_cnt_en;
  logic       o_cnt_clr;
  logic [3:0] o_tap_sel;
  logic       o_tap_upd;
  logic [1:0] o_state;

  modport master (
    output i_key1_mode, i_key2_clear, i_rotary,
    input  o_cnt_en, o_cnt_clr, o_tap_sel, o_tap_upd, o_state
  );

  modport slave (
    input  i_key1_mode, i_key2_clear, i_rotary,
    output o_cnt_en, o_cnt_clr, o_tap_sel, o_tap_upd, o_state
  );

endinterface

// File: rtl/debounce_filter.sv
// rtl/debounce_filter.sv - 2-flop synchronizer plus stability filter for a W-bit raw input
module debounce_filter
  import counter_pkg::*;
#(
  parameter int unsigned  W        = 1,
  parameter int unsigned  P_DB_CNT = P_DB_CNT_DEF,
  parameter int unsigned  CW       = 19,
  parameter logic [W-1:0] RST_VAL  = '1
) (
  input  logic         i_clk,
  input  logic         i_rstn,
  input  logic [W-1:0] i_raw,
  output logic [W-1:0] o_stable
);

  localparam logic [CW-1:0] CNT_LAST = CW'(P_DB_CNT - 1);

  logic [W-1:0]  sync1_q, sync1_d;
  logic [W-1:0]  sync2_q, sync2_d;
  logic [W-1:0]  stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Counter only runs while synced and stable disagree; any agreement restarts it.
  always_comb begin
    sync1_d  = i_raw;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      sync1_q  <= RST_VAL;
      sync2_q  <= RST_VAL;
      stable_q <= RST_VAL;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign o_stable = stable_q;

endmodule

// File: rtl/counter_ctrl.sv
// rtl/counter_ctrl.sv - debounced run/pause/clear sequencer and tap select for the counter datapath
module counter_ctrl
  import counter_pkg::*;
#(
  parameter int unsigned P_DB_CNT = P_DB_CNT_DEF,
  parameter int unsigned P_DB_W   = 19
) (
  input logic           i_clk,
  input logic           i_rstn,
  counter_ctrl_if.slave bus
);

  logic       key1_st, key2_st;
  logic [3:0] rot_st;

  debounce_filter #(.W(1), .P_DB_CNT(P_DB_CNT), .CW(P_DB_W), .RST_VAL(1'b1)) u_db_key1 (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_raw(bus.i_key1_mode), .o_stable(key1_st)
  );

  debounce_filter #(.W(1), .P_DB_CNT(P_DB_CNT), .CW(P_DB_W), .RST_VAL(1'b1)) u_db_key2 (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_raw(bus.i_key2_clear), .o_stable(key2_st)
  );

  debounce_filter #(.W(4), .P_DB_CNT(P_DB_CNT), .CW(P_DB_W), .RST_VAL(4'hF)) u_db_rot (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_raw(bus.i_rotary), .o_stable(rot_st)
  );

  logic       key1_prev_q, key1_prev_d, key2_prev_q, key2_prev_d;
  logic       key1_ev_q, key1_ev_d, key2_ev_q, key2_ev_d;
  state_t     state_q, state_d;
  logic       cnt_en_q, cnt_en_d, cnt_clr_q, cnt_clr_d;
  logic [3:0] tap_sel_q, tap_sel_d;
  logic       tap_upd_q, tap_upd_d;

  always_comb begin
    key1_prev_d = key1_st;
    key2_prev_d = key2_st;
    key1_ev_d   = key1_prev_q & ~key1_st;
    key2_ev_d   = key2_prev_q & ~key2_st;
    state_d     = state_q;
    // Clear has priority over mode; events landing in S_CLEAR are discarded.
    case (state_q)
      S_IDLE, S_PAUSE: begin
        if (key2_ev_q)      state_d = S_CLEAR;
        else if (key1_ev_q) state_d = S_RUN;
      end
      S_RUN: begin
        if (key2_ev_q)      state_d = S_CLEAR;
        else if (key1_ev_q) state_d = S_PAUSE;
      end
      default: state_d = S_IDLE;
    endcase
    cnt_en_d  = (state_d == S_RUN);
    cnt_clr_d = (state_d == S_CLEAR);
    tap_sel_d = ~rot_st;
    tap_upd_d = (~rot_st != tap_sel_q);
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      key1_prev_q <= 1'b1;
      key2_prev_q <= 1'b1;
      key1_ev_q   <= 1'b0;
      key2_ev_q   <= 1'b0;
      state_q     <= S_IDLE;
      cnt_en_q    <= 1'b0;
      cnt_clr_q   <= 1'b0;
      tap_sel_q   <= 4'h0;
      tap_upd_q   <= 1'b0;
    end else begin
      key1_prev_q <= key1_prev_d;
      key2_prev_q <= key2_prev_d;
      key1_ev_q   <= key1_ev_d;
      key2_ev_q   <= key2_ev_d;
      state_q     <= state_d;
      cnt_en_q    <= cnt_en_d;
      cnt_clr_q   <= cnt_clr_d;
      tap_sel_q   <= tap_sel_d;
      tap_upd_q   <= tap_upd_d;
    end
  end

  assign bus.o_cnt_en  = cnt_en_q;
  assign bus.o_cnt_clr = cnt_clr_q;
  assign bus.o_tap_sel = tap_sel_q;
  assign bus.o_tap_upd = tap_upd_q;
  assign bus.o_state   = state_q;

endmodule

// File: tb/tb_counter_ctrl.sv
// tb/tb_counter_ctrl.sv - self-checking bench for counter_ctrl
module tb_counter_ctrl;

  localparam int P = 8;

  logic clk;
  logic rstn;
  counter_ctrl_if bus ();

  counter_ctrl #(.P_DB_CNT(P), .P_DB_W(4)) dut (
    .i_clk (clk),
    .i_rstn(rstn),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] st;
    logic       en;
    logic       clr;
    logic [3:0] tap;
    logic       upd;
  } exp_t;

  typedef struct {
    logic       k1;
    logic       k2;
    logic [3:0] rot;
    logic [1:0] st;
    logic       en;
    logic [3:0] tap;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[10];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic push(input logic [1:0] st, input logic en, input logic clr,
                      input logic [3:0] tap, input logic upd);
    sb.push_back('{st, en, clr, tap, upd});
  endtask

  task automatic check(input string nm);
    exp_t e;
    n_checks++;
    if (sb.size() == 0) begin
      n_errors++;
      $display("FAIL %s: no expected entry queued", nm);
      return;
    end
    e = sb.pop_front();
    if (bus.o_state !== e.st || bus.o_cnt_en !== e.en || bus.o_cnt_clr !== e.clr ||
        bus.o_tap_sel !== e.tap || bus.o_tap_upd !== e.upd) begin
      n_errors++;
      $display("FAIL %s: got state=%b en=%b clr=%b tap=%h upd=%b, expected state=%b en=%b clr=%b tap=%h upd=%b",
               nm, bus.o_state, bus.o_cnt_en, bus.o_cnt_clr, bus.o_tap_sel, bus.o_tap_upd,
               e.st, e.en, e.clr, e.tap, e.upd);
    end
  endtask

  task automatic check_val(input string nm, input int got, input int expv);
    n_checks++;
    if (got != expv) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, expv);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int clr_cnt, en_after, upd_cnt, chg_cnt;
    logic seen, after, found;
    logic [1:0] prev_st;

    vecs[0] = '{1'b1, 1'b1, 4'hF, 2'b00, 1'b0, 4'h0};
    vecs[1] = '{1'b0, 1'b1, 4'hF, 2'b01, 1'b1, 4'h0};
    vecs[2] = '{1'b0, 1'b1, 4'hF, 2'b10, 1'b0, 4'h0};
    vecs[3] = '{1'b0, 1'b1, 4'hF, 2'b01, 1'b1, 4'h0};
    vecs[4] = '{1'b1, 1'b1, 4'hA, 2'b01, 1'b1, 4'h5};
    vecs[5] = '{1'b1, 1'b0, 4'hA, 2'b00, 1'b0, 4'h5};
    vecs[6] = '{1'b0, 1'b1, 4'hA, 2'b01, 1'b1, 4'h5};
    vecs[7] = '{1'b1, 1'b1, 4'h3, 2'b01, 1'b1, 4'hC};
    vecs[8] = '{1'b0, 1'b1, 4'h3, 2'b10, 1'b0, 4'hC};
    vecs[9] = '{1'b1, 1'b0, 4'h3, 2'b00, 1'b0, 4'hC};

    bus.i_key1_mode  = 1'b1;
    bus.i_key2_clear = 1'b1;
    bus.i_rotary     = 4'hF;
    rstn = 1'b1;
    #1 rstn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    push(2'b00, 1'b0, 1'b0, 4'h0, 1'b0);
    check("reset_state");
    rstn = 1'b1;

    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      bus.i_key1_mode  = vecs[i].k1;
      bus.i_key2_clear = vecs[i].k2;
      bus.i_rotary     = vecs[i].rot;
      push(vecs[i].st, vecs[i].en, 1'b0, vecs[i].tap, 1'b0);
      repeat (12) @(posedge clk);
      #1;
      bus.i_key1_mode  = 1'b1;
      bus.i_key2_clear = 1'b1;
      repeat (25) @(posedge clk);
      @(negedge clk);
      check($sformatf("vec%0d", i));
    end

    // Key latency: first sampling edge t is the posedge after the drive.
    @(posedge clk);
    #1 bus.i_key1_mode = 1'b0;
    repeat (P + 3) @(posedge clk);
    @(negedge clk);
    push(2'b00, 1'b0, 1'b0, 4'hC, 1'b0);
    check("key_lat_before");
    @(posedge clk);
    @(negedge clk);
    push(2'b01, 1'b1, 1'b0, 4'hC, 1'b0);
    check("key_lat_after");
    repeat (8) @(posedge clk);
    #1 bus.i_key1_mode = 1'b1;
    repeat (25) @(posedge clk);

    // Bounced key: every low run is shorter than P.
    @(posedge clk);
    #1 bus.i_key1_mode = 1'b0;
    repeat (5) @(posedge clk);
    #1 bus.i_key1_mode = 1'b1;
    repeat (3) @(posedge clk);
    #1 bus.i_key1_mode = 1'b0;
    repeat (6) @(posedge clk);
    #1 bus.i_key1_mode = 1'b1;
    repeat (30) @(posedge clk);
    @(negedge clk);
    push(2'b01, 1'b1, 1'b0, 4'hC, 1'b0);
    check("bounce_rejected");

    // Long hold gives exactly one transition.
    chg_cnt = 0;
    prev_st = bus.o_state;
    bus.i_key1_mode = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (i == 20) bus.i_key1_mode = 1'b1;
      if (bus.o_state != prev_st) chg_cnt++;
      prev_st = bus.o_state;
    end
    check_val("hold_one_transition", chg_cnt, 1);
    push(2'b10, 1'b0, 1'b0, 4'hC, 1'b0);
    check("hold_to_pause");

    // Simultaneous key1+key2 from S_RUN: clear wins.
    @(posedge clk);
    #1 bus.i_key1_mode = 1'b0;
    repeat (12) @(posedge clk);
    #1 bus.i_key1_mode = 1'b1;
    repeat (25) @(posedge clk);
    @(negedge clk);
    push(2'b01, 1'b1, 1'b0, 4'hC, 1'b0);
    check("back_to_run");

    clr_cnt = 0; en_after = 0; seen = 1'b0; after = 1'b0;
    bus.i_key1_mode  = 1'b0;
    bus.i_key2_clear = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 12) begin
        bus.i_key1_mode  = 1'b1;
        bus.i_key2_clear = 1'b1;
      end
      if (bus.o_cnt_clr) clr_cnt++;
      if (seen && bus.o_cnt_en) en_after++;
      if (seen && !after) begin
        after = 1'b1;
        push(2'b00, 1'b0, 1'b0, 4'hC, 1'b0);
        check("clear_then_idle");
      end else if (!seen && bus.o_cnt_clr) begin
        seen = 1'b1;
        push(2'b11, 1'b0, 1'b1, 4'hC, 1'b0);
        check("clear_state");
      end
    end
    check_val("clear_pulse_count", clr_cnt, 1);
    check_val("en_after_clear", en_after, 0);

    // Rotary latency and single update pulse.
    @(posedge clk);
    #1 bus.i_rotary = 4'hA;
    repeat (P + 2) @(posedge clk);
    @(negedge clk);
    push(2'b00, 1'b0, 1'b0, 4'hC, 1'b0);
    check("rot_lat_before");
    @(posedge clk);
    @(negedge clk);
    push(2'b00, 1'b0, 1'b0, 4'h5, 1'b1);
    check("rot_upd_pulse");
    @(posedge clk);
    @(negedge clk);
    push(2'b00, 1'b0, 1'b0, 4'h5, 1'b0);
    check("rot_upd_single");

    upd_cnt = 0;
    @(posedge clk);
    #1 bus.i_rotary = 4'h0;
    repeat (3) @(posedge clk);
    #1 bus.i_rotary = 4'hA;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.o_tap_upd) upd_cnt++;
    end
    check_val("rot_glitch_no_pulse", upd_cnt, 0);
    push(2'b00, 1'b0, 1'b0, 4'h5, 1'b0);
    check("rot_glitch_no_change");

    // Asynchronous reset while in S_CLEAR.
    found = 1'b0;
    @(posedge clk);
    #1;
    bus.i_rotary     = 4'hF;
    bus.i_key2_clear = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.o_cnt_clr) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      n_checks++;
      n_errors++;
      $display("FAIL reach_clear: o_cnt_clr never rose within 40 cycles");
    end
    #2 rstn = 1'b0;
    #1;
    push(2'b00, 1'b0, 1'b0, 4'h0, 1'b0);
    check("rst_mid_clear");
    bus.i_key2_clear = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    repeat (30) @(posedge clk);
    @(negedge clk);
    push(2'b00, 1'b0, 1'b0, 4'h0, 1'b0);
    check("post_clear_idle");

    // Asynchronous reset while key1 is partially qualified.
    @(posedge clk);
    #1 bus.i_key1_mode = 1'b0;
    repeat (5) @(posedge clk);
    #3 rstn = 1'b0;
    #1;
    push(2'b00, 1'b0, 1'b0, 4'h0, 1'b0);
    check("rst_mid_debounce");
    bus.i_key1_mode = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    repeat (30) @(posedge clk);
    @(negedge clk);
    push(2'b00, 1'b0, 1'b0, 4'h0, 1'b0);
    check("no_spurious_event");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
